// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// fifo_uart_tx_if : FIFO read-port bundle between a FIFO and its UART drain | rev 1.0
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;

  // master = the drain that owns r_en; slave = the FIFO
  modport master (input fifo_empty, input fifo_data, output fifo_r_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_r_en);
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// fifo_uart_tx : pops FIFO bytes and serialises them as UART frames | rev 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          enable,
  fifo_uart_tx_if.master     fifo,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_DATA_BITS = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0]  c_STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              c_ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parity;

  logic w_in_frame;
  logic w_bit_end;

  assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_bit_end  = (r_baud == c_BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_baud         <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_parity       <= 1'b0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      fifo.fifo_r_en <= 1'b0;
    end else begin
      fifo.fifo_r_en <= 1'b0;
      frame_done     <= 1'b0;

      // Baud counter only runs inside a frame, so it is zero on entry to START
      if (w_in_frame && !w_bit_end) begin
        r_baud <= r_baud + 1'b1;
      end else begin
        r_baud <= '0;
      end

      case (r_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo.fifo_empty) begin
            r_state        <= S_READ;
            fifo.fifo_r_en <= 1'b1;
            busy           <= 1'b1;
          end
        end

        S_READ: begin
          r_state <= S_LOAD;
        end

        S_LOAD: begin
          r_shift   <= fifo.fifo_data;
          r_parity  <= 1'b0;
          r_bit_cnt <= '0;
          tx        <= 1'b0;
          r_state   <= S_START;
        end

        S_START: begin
          if (w_bit_end) begin
            tx        <= r_shift[0];
            r_parity  <= r_parity ^ r_shift[0];
            r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= BIT_W'(1);
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            // r_bit_cnt counts bits already placed on the line
            if (r_bit_cnt == c_DATA_BITS) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx      <= r_parity ^ c_ODD;
                r_state <= S_PARITY;
              end else begin
                tx      <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              tx        <= r_shift[0];
              r_parity  <= r_parity ^ r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            tx        <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == c_STOP_LAST) begin
              r_bit_cnt  <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
